// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// The misaligned-redirect feature of inst_fetch is enabled with INST_FETCH_MISALIGN_EN.
package inst_fetch_pkg;

    typedef logic [31:0] inst_bus_t;
    typedef logic [31:0] inst_addr_bus_t;

    localparam inst_bus_t      INST_NOP         = 32'h0000_0013;
    localparam inst_addr_bus_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        inst_addr_bus_t addr;
        inst_bus_t      inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// In-order buffer of {addr, inst} entries between the fetch port and decode.
// Clear has priority over push/pop; pop of an empty buffer is ignored.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1'b1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [PW:0]   count_nxt_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_pop_s  = pop && (count_r != {(PW + 1){1'b0}});
    assign do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: PC, fetch credit, stale-response dropping and address queue.
// Define INST_FETCH_MISALIGN_EN to add o_misalign and block fetch on misaligned redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_jump_flag,
    input  logic [31:0] i_jump_addr,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_addr,
    input  logic        i_id_ready
`ifdef INST_FETCH_MISALIGN_EN
    ,
    output logic        o_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = CW - 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);

    logic [31:0]   pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;
    logic [31:0]   aq_mem_r [FIFO_DEPTH];
    logic [PW-1:0] aq_wr_r;
    logic [PW-1:0] aq_rd_r;
    logic [CW-1:0] fifo_count_s;
    fetch_entry_t  fifo_head_s;
    fetch_entry_t  push_entry_s;
    logic          credit_s;
    logic          fetch_block_s;
    logic          grant_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   jump_pc_s;

`ifdef INST_FETCH_MISALIGN_EN
    logic misalign_r;

    // Sticky misaligned-target flag, re-evaluated on every redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else if (i_jump_flag) begin
            misalign_r <= (i_jump_addr[1:0] != 2'b00);
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign o_misalign    = misalign_r;
    assign fetch_block_s = misalign_r;
    assign jump_pc_s     = i_jump_addr;
`else
    assign fetch_block_s = 1'b0;
    assign jump_pc_s     = i_jump_addr & 32'hFFFF_FFFC;
`endif

    // Every granted fetch already owns a buffer slot, so responses never overflow.
    assign credit_s   = ({1'b0, fifo_count_s} + {1'b0, outstanding_r}) < {1'b0, DEPTH_CNT};
    assign o_mem_req  = !i_jump_flag && credit_s && !fetch_block_s;
    assign o_mem_addr = pc_r;
    assign grant_s    = o_mem_req && i_mem_gnt;
    assign push_s     = i_mem_rvalid && (drop_cnt_r == {CW{1'b0}}) && !i_jump_flag;
    assign pop_s      = o_inst_valid && i_id_ready;

    // PC, in-flight count and number of stale responses still to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            if (i_jump_flag) begin
                pc_r <= jump_pc_s;
            end else if (grant_s) begin
                pc_r <= pc_r + 32'd4;
            end else begin
                pc_r <= pc_r;
            end
            case ({grant_s, i_mem_rvalid})
                2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
                2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
                default: outstanding_r <= outstanding_r;
            endcase
            if (i_jump_flag) begin
                drop_cnt_r <= outstanding_r - {{(CW - 1){1'b0}}, i_mem_rvalid};
            end else if (i_mem_rvalid && (drop_cnt_r != {CW{1'b0}})) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Address of each granted fetch, consumed by its in-order response (kept or dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_wr_r <= {PW{1'b0}};
            aq_rd_r <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) aq_mem_r[i] <= 32'h0000_0000;
        end else begin
            if (grant_s) begin
                aq_mem_r[aq_wr_r] <= pc_r;
                aq_wr_r           <= aq_wr_r + PTR_ONE;
            end
            if (i_mem_rvalid) aq_rd_r <= aq_rd_r + PTR_ONE;
        end
    end

    assign push_entry_s = '{addr: aq_mem_r[aq_rd_r], inst: i_mem_rdata};

    inst_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_inst_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (i_jump_flag),
        .push     (push_s),
        .push_data(push_entry_s),
        .pop      (pop_s),
        .head     (fifo_head_s),
        .count    (fifo_count_s)
    );

    // Decode-side view of the buffer head; NOP at address 0 when empty.
    always_comb begin
        if (fifo_count_s != {CW{1'b0}}) begin
            o_inst_valid = 1'b1;
            o_inst       = fifo_head_s.inst;
            o_inst_addr  = fifo_head_s.addr;
        end else begin
            o_inst_valid = 1'b0;
            o_inst       = INST_NOP;
            o_inst_addr  = 32'h0000_0000;
        end
    end

endmodule
